// File: rtl/score_sequencer.sv
// rtl/score_sequencer.sv - point sequencer: accepts brick hits, meters them out at up to 3 per cycle until the win score
module score_sequencer #(
    parameter int WIN_SCORE = 24,
    parameter int PEND_MAX  = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic [7:0] hit,
    output logic [1:0] total_score,
    output logic [4:0] pending,
    output logic [6:0] issued,
    output logic       overflow,
    output logic       win,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     cur;
    logic [3:0] hit_count;
    logic [6:0] remaining;
    logic [1:0] grant;
    logic [5:0] pend_sum;
    logic       pend_sat;
    logic [6:0] issued_next;
    logic       reach_win;

    assign state = cur;

    always_comb begin
        hit_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            hit_count = hit_count + 4'(hit[i]);
        end
    end

    // Grant is limited by what is queued, the per-cycle cap of 3, and the
    // points still needed to win, so issued can never overshoot WIN_SCORE.
    always_comb begin
        remaining = 7'(WIN_SCORE) - issued;
        grant     = 2'd0;
        if (cur == RUN && !pause) begin
            grant = 2'd3;
            if (pending < 5'd3) begin
                grant = pending[1:0];
            end
            if (remaining < 7'(grant)) begin
                grant = remaining[1:0];
            end
        end
    end

    always_comb begin
        pend_sum    = 6'(pending) - 6'(grant) + 6'(hit_count);
        pend_sat    = pend_sum > 6'(PEND_MAX);
        issued_next = issued + 7'(grant);
        reach_win   = issued_next == 7'(WIN_SCORE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= IDLE;
            total_score <= 2'd0;
            pending     <= 5'd0;
            issued      <= 7'd0;
            overflow    <= 1'b0;
            win         <= 1'b0;
        end else begin
            case (cur)
                IDLE: begin
                    total_score <= 2'd0;
                    if (start) begin
                        cur <= RUN;
                    end
                end
                RUN: begin
                    total_score <= grant;
                    issued      <= issued_next;
                    if (pend_sat) begin
                        pending  <= 5'(PEND_MAX);
                        overflow <= 1'b1;
                    end else begin
                        pending <= pend_sum[4:0];
                    end
                    if (reach_win) begin
                        cur <= DONE;
                        win <= 1'b1;
                    end
                end
                DONE: begin
                    total_score <= 2'd0;
                    win         <= 1'b1;
                end
                default: begin
                    cur         <= IDLE;
                    total_score <= 2'd0;
                    win         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_sequencer.sv
// tb/tb_score_sequencer.sv - scoreboard bench for score_sequencer
module tb_score_sequencer;

    localparam int WIN = 24;
    localparam int PMAX = 31;

    logic       clk = 1'b0;
    logic       reset, start, pause;
    logic [7:0] hit;
    logic [1:0] total_score;
    logic [4:0] pending;
    logic [6:0] issued;
    logic       overflow, win;
    logic [1:0] state;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int st;
        int ts;
        int pend;
        int iss;
        int ovf;
        int w;
    } exp_t;

    exp_t exp_q[$];

    int m_st = 0, m_ts = 0, m_pend = 0, m_iss = 0, m_ovf = 0, m_w = 0;

    score_sequencer #(.WIN_SCORE(WIN), .PEND_MAX(PMAX)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pause(pause),
        .hit(hit),
        .total_score(total_score),
        .pending(pending),
        .issued(issued),
        .overflow(overflow),
        .win(win),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference behaviour for one clock edge, written from the requirements.
    task automatic model_edge(input int r, input int s, input int p, input logic [7:0] h);
        int g, raw;
        exp_t e;
        if (r != 0) begin
            m_st = 0; m_ts = 0; m_pend = 0; m_iss = 0; m_ovf = 0; m_w = 0;
        end else if (m_st == 0) begin
            m_ts = 0;
            if (s != 0) m_st = 1;
        end else if (m_st == 1) begin
            g = 0;
            if (p == 0) begin
                g = m_pend;
                if (g > 3) g = 3;
                if (g > WIN - m_iss) g = WIN - m_iss;
            end
            raw = m_pend - g + $countones(h);
            if (raw > PMAX) begin
                m_pend = PMAX;
                m_ovf = 1;
            end else begin
                m_pend = raw;
            end
            m_ts = g;
            m_iss = m_iss + g;
            if (m_iss == WIN) begin
                m_st = 2;
                m_w = 1;
            end
        end else begin
            m_ts = 0;
        end
        e.st = m_st; e.ts = m_ts; e.pend = m_pend; e.iss = m_iss; e.ovf = m_ovf; e.w = m_w;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic p, input logic [7:0] h);
        exp_t e;
        reset = r; start = s; pause = p; hit = h;
        model_edge(int'(r), int'(s), int'(p), h);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("state", 32'(state), 32'(e.st));
            check("total_score", 32'(total_score), 32'(e.ts));
            check("pending", 32'(pending), 32'(e.pend));
            check("issued", 32'(issued), 32'(e.iss));
            check("overflow", 32'(overflow), 32'(e.ovf));
            check("win", 32'(win), 32'(e.w));
        end
    endtask

    initial begin
        int k, guard;
        logic [7:0] mask;
        reset = 1'b1; start = 1'b0; pause = 1'b0; hit = 8'h00;
        @(posedge clk);
        #1;

        // reset priority over start/hit
        step(1'b1, 1'b1, 1'b0, 8'hFF);
        check("rst_state", 32'(state), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);

        // hits ignored in IDLE
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h0F);
        check("idle_pending", 32'(pending), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("run_entry", 32'(state), 32'd1);

        // three hits, then issued next edge
        step(1'b0, 1'b0, 1'b0, 8'h07);
        check("p3", 32'(pending), 32'd3);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("ts3", 32'(total_score), 32'd3);
        check("iss3", 32'(issued), 32'd3);

        // burst of 8 drains as 3,3,2,0
        step(1'b0, 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        check("iss11", 32'(issued), 32'd11);

        // paused saturation
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'hFF);
        check("sat_pend", 32'(pending), 32'd31);
        check("sat_ovf", 32'(overflow), 32'd1);

        // drain to the win, last grant clipped to 1
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        check("win1", 32'(win), 32'd1);
        check("iss_win1", 32'(issued), 32'd24);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 8'hFF);

        // exact win boundary from issued=22
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        guard = 0;
        while (m_iss < 22 && guard < 100) begin
            k = 22 - m_iss - m_pend;
            if (k > 3) k = 3;
            if (k < 0) k = 0;
            mask = (8'd1 << k) - 8'd1;
            step(1'b0, 1'b0, 1'b0, mask);
            guard++;
        end
        check("reach22_bound", 32'(guard < 100), 32'd1);
        check("iss22", 32'(issued), 32'd22);
        step(1'b0, 1'b0, 1'b0, 8'h1F);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("fin_ts", 32'(total_score), 32'd2);
        check("fin_iss", 32'(issued), 32'd24);
        check("fin_state", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'hFF);
        check("done_pend", 32'(pending), 32'd3);
        check("done_ts", 32'(total_score), 32'd0);

        // mid-round reset discards pending points
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 8'h03);
        check("p10", 32'(pending), 32'd10);
        step(1'b1, 1'b0, 1'b0, 8'hFF);
        check("mid_rst_pend", 32'(pending), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("post_rst_ts", 32'(total_score), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
